mem_access_ctrl: RTL and testbench
==================================

// Module: mem_access_ctrl
// PURPOSE
//  Initiator side of the data-memory port. Accepts one load/store request at a time from
//  the execute/memory stage and drives the word-indexed data memory (A, WE, WD, RD).
//  Supports word and byte accesses. Byte stores use read-modify-write because the
//  memory only writes full words. Returns one response per request.
// PARAMETERS
//  MEM_WORDS  1024  words in target memory; word index >= MEM_WORDS faults
//  RD_WAIT    1     cycles mem_A is held before mem_RD is sampled (>=1)
// PORTS
//  clk         in   1   rising-edge clock
//  rst         in   1   synchronous reset, active-low
//  req_valid   in   1   request present
//  req_ready   out  1   controller idle, may accept
//  req_we      in   1   1=store, 0=load
//  req_byte    in   1   1=byte access, 0=word access
//  req_addr    in   32  byte address
//  req_wdata   in   32  store data (byte store uses [7:0])
//  resp_valid  out  1   one-cycle response strobe
//  resp_rdata  out  32  load data (zero for stores/faults)
//  resp_fault  out  1   misaligned or out-of-range access
//  mem_A       out  32  word index = {2'b0, addr[31:2]}
//  mem_WE      out  1   memory write enable
//  mem_WD      out  32  memory write data
//  mem_RD      in   32  memory read data (combinational from mem_A)
// BEHAVIOUR
//  - rst low at a clock edge: state=IDLE; req_ready, resp_valid, resp_fault, mem_WE=0;
//    resp_rdata, mem_A, mem_WD=0. req_ready is 0 while rst is low and 1 in IDLE after reset.
//  - States: IDLE, READ, WRITE, RESP. Outputs are registered. req_ready=1 only in IDLE.
//  - Accept in cycle T when req_valid && req_ready. addr/we/byte/wdata latched at that edge.
//    mem_A is held at the latched index from T+1 until IDLE is re-entered.
//  - Fault check at accept: word access with addr[1:0]!=0, or addr[31:2] >= MEM_WORDS.
//    IDLE->RESP with resp_fault=1 and resp_rdata=0. mem_WE is never asserted. resp_valid at T+1.
//  - Word store: IDLE->WRITE. mem_WE=1 and mem_WD=wdata in T+1 only. RESP at T+2.
//  - Load: IDLE->READ. A wait counter runs RD_WAIT cycles (T+1..T+RD_WAIT). mem_RD is
//    sampled on the last READ cycle. RESP at T+RD_WAIT+1.
//    Word load: rdata=mem_RD. Byte load: lane=addr[1:0], little-endian (lane0=[7:0]),
//    zero-extended.
//  - Byte store: READ as for a load. Then WRITE for one cycle with mem_WD = sampled word,
//    with lane addr[1:0] replaced by wdata[7:0]. RESP at T+RD_WAIT+2.
//  - RESP: resp_valid=1 for exactly one cycle, no backpressure. Next state is IDLE, so
//    req_ready=1 in the following cycle. resp_rdata/resp_fault are valid only with
//    resp_valid and are 0 otherwise.
//  - mem_WE is high only in WRITE, at most one cycle per request.
//  - req_valid outside IDLE is ignored; the requester must hold the request until accepted.
//  - Reset mid-operation (any state): abort. No write occurs at or after the reset edge.
//    The pending response is dropped. Restart in IDLE.
//  - Back-to-back: new accept is possible the cycle after RESP. Max throughput is
//    one word store per 3 cycles.
// TESTING (RD_WAIT=1; memory preload word28=0x00000020, word40=0x00000002)
//  1. Word load addr=0x70 -> resp_valid at T+2, resp_rdata=0x00000020, fault=0, mem_WE never high.
//  2. Word store addr=0xA0, wdata=0xDEADBEEF -> mem_WE=1 at T+1 only, mem_A=40.
//     Reload of 0xA0 returns 0xDEADBEEF.
//  3. Byte store addr=0x71, wdata=0xAB -> mem_WD=0x0000AB20 at T+2.
//     Byte load 0x71 returns 0x000000AB. Word load 0x70 returns 0x0000AB20.
//  4. Word load addr=0x72 -> resp_fault=1, resp_rdata=0 at T+1, no memory write.
//     addr=0x1000 (index 1024) also faults.
//  5. Byte store started, rst driven low during READ -> mem_WE stays 0, no resp_valid,
//     word28 unchanged, req_ready=1 after rst released.
//  6. req_valid held high for 4 requests -> req_ready low except IDLE.
//     Exactly one resp_valid per accepted request, in order.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Load/store initiator for a word-indexed data memory with byte access support.
// Byte stores are performed as read-modify-write of the containing word.
module mem_access_ctrl #(
  parameter int MEM_WORDS = 1024,
  parameter int RD_WAIT   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic        req_byte,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic [31:0] mem_A,
  output logic        mem_WE,
  output logic [31:0] mem_WD,
  input  logic [31:0] mem_RD
);

  localparam int CW = (RD_WAIT > 1) ? $clog2(RD_WAIT) : 1;

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t      state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic        lat_we, lat_we_nxt;
  logic        lat_byte, lat_byte_nxt;
  logic [1:0]  lat_lane, lat_lane_nxt;
  logic [7:0]  lat_wbyte, lat_wbyte_nxt;
  logic        we_q, we_nxt;
  logic        ready_nxt, rvalid_nxt, fault_nxt;
  logic [31:0] rdata_nxt, addr_nxt, wd_nxt;
  logic        fault_chk;

  function automatic logic [31:0] lane_extract(input logic [31:0] w, input logic [1:0] lane);
    logic [31:0] r;
    r = '0;
    r[7:0] = w[{lane, 3'b000} +: 8];
    return r;
  endfunction

  function automatic logic [31:0] lane_insert(input logic [31:0] w, input logic [1:0] lane,
                                              input logic [7:0] b);
    logic [31:0] r;
    r = w;
    r[{lane, 3'b000} +: 8] = b;
    return r;
  endfunction

  assign fault_chk = (!req_byte && (req_addr[1:0] != 2'b00)) ||
                     ({2'b00, req_addr[31:2]} >= 32'(MEM_WORDS));

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    lat_we_nxt    = lat_we;
    lat_byte_nxt  = lat_byte;
    lat_lane_nxt  = lat_lane;
    lat_wbyte_nxt = lat_wbyte;
    addr_nxt      = mem_A;
    wd_nxt        = mem_WD;
    we_nxt        = 1'b0;
    ready_nxt     = 1'b0;
    rvalid_nxt    = 1'b0;
    fault_nxt     = 1'b0;
    rdata_nxt     = '0;
    case (state)
      IDLE: begin
        if (req_valid && req_ready) begin
          lat_we_nxt    = req_we;
          lat_byte_nxt  = req_byte;
          lat_lane_nxt  = req_addr[1:0];
          lat_wbyte_nxt = req_wdata[7:0];
          addr_nxt      = {2'b00, req_addr[31:2]};
          if (fault_chk) begin
            state_nxt  = RESP;
            rvalid_nxt = 1'b1;
            fault_nxt  = 1'b1;
          end else if (req_we && !req_byte) begin
            state_nxt = WRITE;
            we_nxt    = 1'b1;
            wd_nxt    = req_wdata;
          end else begin
            state_nxt = READ;
            cnt_nxt   = CW'(RD_WAIT - 1);
          end
        end else begin
          ready_nxt = 1'b1;
        end
      end
      READ: begin
        // mem_RD is only trusted after mem_A has been stable for RD_WAIT cycles
        if (cnt == '0) begin
          if (lat_we) begin
            state_nxt = WRITE;
            we_nxt    = 1'b1;
            wd_nxt    = lane_insert(mem_RD, lat_lane, lat_wbyte);
          end else begin
            state_nxt  = RESP;
            rvalid_nxt = 1'b1;
            rdata_nxt  = lat_byte ? lane_extract(mem_RD, lat_lane) : mem_RD;
          end
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      WRITE: begin
        state_nxt  = RESP;
        rvalid_nxt = 1'b1;
      end
      RESP: begin
        state_nxt = IDLE;
        ready_nxt = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      lat_we     <= 1'b0;
      lat_byte   <= 1'b0;
      lat_lane   <= 2'b00;
      lat_wbyte  <= '0;
      we_q       <= 1'b0;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_fault <= 1'b0;
      resp_rdata <= '0;
      mem_A      <= '0;
      mem_WD     <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      lat_we     <= lat_we_nxt;
      lat_byte   <= lat_byte_nxt;
      lat_lane   <= lat_lane_nxt;
      lat_wbyte  <= lat_wbyte_nxt;
      we_q       <= we_nxt;
      req_ready  <= ready_nxt;
      resp_valid <= rvalid_nxt;
      resp_fault <= fault_nxt;
      resp_rdata <= rdata_nxt;
      mem_A      <= addr_nxt;
      mem_WD     <= wd_nxt;
    end
  end

  // Gating with rst keeps a reset that lands on a WRITE cycle from committing the write.
  assign mem_WE = we_q & rst;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a behavioural word memory (RD_WAIT=1).
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_byte;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_fault;
  logic [31:0] resp_rdata;
  logic [31:0] mem_A, mem_WD, mem_RD;
  logic        mem_WE;

  logic [31:0] mem [0:1023];
  int checks = 0;
  int errors = 0;
  int we_cnt = 0;
  int rv_cnt = 0;
  int viol   = 0;
  logic [31:0] rd_log [0:63];

  mem_access_ctrl #(.MEM_WORDS(1024), .RD_WAIT(1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_byte(req_byte),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
    .mem_A(mem_A), .mem_WE(mem_WE), .mem_WD(mem_WD), .mem_RD(mem_RD)
  );

  always #5 clk = ~clk;

  assign mem_RD = (mem_A < 32'd1024) ? mem[mem_A[9:0]] : 32'h0;

  always @(posedge clk) begin
    if (mem_WE && mem_A < 32'd1024) mem[mem_A[9:0]] <= mem_WD;
  end

  always @(negedge clk) begin
    if (mem_WE) we_cnt = we_cnt + 1;
    if (resp_valid) begin
      if (rv_cnt < 64) rd_log[rv_cnt] = resp_rdata;
      rv_cnt = rv_cnt + 1;
    end
    if (req_ready && (mem_WE || resp_valid)) viol = viol + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input logic we, input logic byt, input logic [31:0] addr,
                        input logic [31:0] wdata, output int lat, output logic [31:0] rdata,
                        output logic fault, output int we_cyc, output logic [31:0] wd_at,
                        output logic [31:0] a_at);
    int n;
    n = 0;
    we_cyc = 0;
    wd_at = '0;
    while (!req_ready && n < 20) begin
      step();
      n++;
    end
    req_valid = 1'b1;
    req_we    = we;
    req_byte  = byt;
    req_addr  = addr;
    req_wdata = wdata;
    step();
    req_valid = 1'b0;
    lat  = 1;
    a_at = mem_A;
    while (!resp_valid && lat < 20) begin
      if (mem_WE) begin
        we_cyc = lat;
        wd_at  = mem_WD;
      end
      step();
      lat++;
    end
    rdata = resp_rdata;
    fault = resp_fault;
  endtask

  initial begin
    int lat, wec, web, rvb, n;
    logic [31:0] rd, wd, aa;
    logic flt;

    for (int i = 0; i < 1024; i++) mem[i] = '0;
    mem[28]   = 32'h0000_0020;
    mem[40]   = 32'h0000_0002;
    mem[1023] = 32'h1234_5678;
    rst = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_byte = 1'b0;
    req_addr = '0; req_wdata = '0;
    step();
    step();
    check("rst_ready", {31'b0, req_ready}, 32'd0);
    check("rst_rvalid", {31'b0, resp_valid}, 32'd0);
    check("rst_fault", {31'b0, resp_fault}, 32'd0);
    check("rst_we", {31'b0, mem_WE}, 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_memA", mem_A, 32'd0);
    check("rst_memWD", mem_WD, 32'd0);
    rst = 1'b1;
    step();
    check("ready_after_rst", {31'b0, req_ready}, 32'd1);

    // 1. word load
    web = we_cnt;
    do_req(1'b0, 1'b0, 32'h70, 32'h0, lat, rd, flt, wec, wd, aa);
    check("ld70_lat", lat, 32'd2);
    check("ld70_data", rd, 32'h0000_0020);
    check("ld70_fault", {31'b0, flt}, 32'd0);
    check("ld70_memA", aa, 32'd28);
    check("ld70_nowrite", we_cnt - web, 32'd0);
    step();
    check("ld70_ready_next", {31'b0, req_ready}, 32'd1);

    // 2. word store then reload
    web = we_cnt;
    do_req(1'b1, 1'b0, 32'hA0, 32'hDEAD_BEEF, lat, rd, flt, wec, wd, aa);
    check("stA0_we_cycle", wec, 32'd1);
    check("stA0_we_count", we_cnt - web, 32'd1);
    check("stA0_wd", wd, 32'hDEAD_BEEF);
    check("stA0_memA", aa, 32'd40);
    check("stA0_lat", lat, 32'd2);
    check("stA0_rdata0", rd, 32'd0);
    do_req(1'b0, 1'b0, 32'hA0, 32'h0, lat, rd, flt, wec, wd, aa);
    check("ldA0_data", rd, 32'hDEAD_BEEF);

    // 3. byte store read-modify-write
    web = we_cnt;
    do_req(1'b1, 1'b1, 32'h71, 32'h0000_00AB, lat, rd, flt, wec, wd, aa);
    check("sb71_we_cycle", wec, 32'd2);
    check("sb71_wd", wd, 32'h0000_AB20);
    check("sb71_lat", lat, 32'd3);
    check("sb71_we_count", we_cnt - web, 32'd1);
    do_req(1'b0, 1'b1, 32'h71, 32'h0, lat, rd, flt, wec, wd, aa);
    check("lb71_data", rd, 32'h0000_00AB);
    check("lb71_lat", lat, 32'd2);
    do_req(1'b0, 1'b0, 32'h70, 32'h0, lat, rd, flt, wec, wd, aa);
    check("ld70_after_sb", rd, 32'h0000_AB20);
    do_req(1'b0, 1'b1, 32'hA3, 32'h0, lat, rd, flt, wec, wd, aa);
    check("lbA3_lane3", rd, 32'h0000_00DE);

    // 4. faults and range boundary
    web = we_cnt;
    do_req(1'b0, 1'b0, 32'h72, 32'h0, lat, rd, flt, wec, wd, aa);
    check("ld72_fault", {31'b0, flt}, 32'd1);
    check("ld72_rdata", rd, 32'd0);
    check("ld72_lat", lat, 32'd1);
    do_req(1'b1, 1'b0, 32'h1000, 32'hFFFF_FFFF, lat, rd, flt, wec, wd, aa);
    check("st1000_fault", {31'b0, flt}, 32'd1);
    check("st1000_lat", lat, 32'd1);
    check("fault_nowrite", we_cnt - web, 32'd0);
    do_req(1'b0, 1'b0, 32'hFFC, 32'h0, lat, rd, flt, wec, wd, aa);
    check("ldFFC_fault", {31'b0, flt}, 32'd0);
    check("ldFFC_data", rd, 32'h1234_5678);

    // 5. reset during READ of a byte store
    step();
    n = 0;
    while (!req_ready && n < 20) begin
      step();
      n++;
    end
    req_valid = 1'b1; req_we = 1'b1; req_byte = 1'b1;
    req_addr = 32'h71; req_wdata = 32'h55;
    step();
    req_valid = 1'b0;
    rst = 1'b0;
    rvb = rv_cnt;
    web = we_cnt;
    step();
    check("abort_rvalid", {31'b0, resp_valid}, 32'd0);
    check("abort_ready", {31'b0, req_ready}, 32'd0);
    step();
    rst = 1'b1;
    step();
    check("abort_ready_after", {31'b0, req_ready}, 32'd1);
    step();
    step();
    check("abort_no_resp", rv_cnt - rvb, 32'd0);
    check("abort_no_write", we_cnt - web, 32'd0);
    check("abort_word28", mem[28], 32'h0000_AB20);

    // 6. req_valid held high across four requests
    rvb = rv_cnt;
    req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: begin req_we = 1'b0; req_byte = 1'b0; req_addr = 32'h70; req_wdata = 32'h0; end
        1: begin req_we = 1'b0; req_byte = 1'b0; req_addr = 32'hA0; req_wdata = 32'h0; end
        2: begin req_we = 1'b1; req_byte = 1'b0; req_addr = 32'h80; req_wdata = 32'h1111_2222; end
        default: begin req_we = 1'b0; req_byte = 1'b0; req_addr = 32'h80; req_wdata = 32'h0; end
      endcase
      n = 0;
      while (!req_ready && n < 20) begin
        step();
        n++;
      end
      step();
    end
    req_valid = 1'b0;
    n = 0;
    while (rv_cnt < rvb + 4 && n < 40) begin
      step();
      n++;
    end
    step();
    step();
    check("burst_resp_count", rv_cnt - rvb, 32'd4);
    check("burst_r0", rd_log[rvb], 32'h0000_AB20);
    check("burst_r1", rd_log[rvb + 1], 32'hDEAD_BEEF);
    check("burst_r2", rd_log[rvb + 2], 32'd0);
    check("burst_r3", rd_log[rvb + 3], 32'h1111_2222);
    check("burst_mem32", mem[32], 32'h1111_2222);
    check("ready_exclusive", viol, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
